// File: rtl/pwm_timer.sv
// -----------------------------------------------------------------------------
// pwm_timer : memory-mapped multi-channel PWM timer, picorv32 native bus slave.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   select   : slave select, already qualified by mem_valid
//   wstrb    : byte write strobes, 4'b0000 means read
//   addr     : byte offset within the 32-byte register block
//   data_i   : write data
//   ready    : access acknowledge (one cycle after select, held while select)
//   data_o   : registered read data, valid together with ready
//   pwm_o    : PWM outputs, one per channel
//   irq      : level interrupt = wrap flag & irq_en
//
// Register map (word offsets)
//   0x00 CTRL   [0] enable, [1] irq_en, [7:4] per-channel output inversion
//   0x04 PRESC  prescaler reload
//   0x08 PERIOD counter period (counter runs 0..PERIOD)
//   0x0C STATUS [0] wrap flag (write 1 to clear), [31:16] live counter
//   0x10..0x1C CMP0..CMP3 compare values
//
// Build option
//   PWM_SHADOW_EN : compare writes go to a buffer that is copied into the
//                   active compare value on every wrap and while disabled.
//                   Without it the written compare value is used directly.
// -----------------------------------------------------------------------------
module pwm_timer #(
  parameter int CNT_WIDTH = 16,
  parameter int CHANNELS  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                select,
  input  logic [3:0]          wstrb,
  input  logic [4:0]          addr,
  input  logic [31:0]         data_i,
  output logic                ready,
  output logic [31:0]         data_o,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                irq
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PRESC  = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  logic                ready_q;
  logic [31:0]         data_q;
  logic                enable_q, enable_d;
  logic                irq_en_q, irq_en_d;
  logic [CHANNELS-1:0] pol_q, pol_d;
  cnt_t                presc_q, presc_d;
  cnt_t                period_q, period_d;
  logic                flag_q, flag_d;
  cnt_t                pcnt_q, pcnt_d;
  cnt_t                cnt_q, cnt_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  cnt_t                cmp_rd [CHANNELS];

  logic        access, wr_en, w1c, tick, wrap;
  logic [2:0]  reg_sel;
  cnt_t        wmask;
  logic [31:0] rdata, cnt_ext;
  logic        unused_bits;

  // An access happens once per select assertion: in the first cycle, before
  // ready has been returned.
  assign access  = select & ~ready_q;
  assign wr_en   = access & (|wstrb);
  assign reg_sel = addr[4:2];
  assign w1c     = wr_en && (reg_sel == REG_STATUS) && wstrb[0] && data_i[0];

  // Per-bit write mask derived from the byte strobes.
  generate
    for (genvar gi = 0; gi < CNT_WIDTH; gi++) begin : g_wmask
      assign wmask[gi] = wstrb[gi/8];
    end
  endgenerate

  function automatic cnt_t merge(input cnt_t old_v, input cnt_t new_v, input cnt_t m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Configuration register writes.
  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    pol_d    = pol_q;
    presc_d  = presc_q;
    period_d = period_q;
    if (wr_en) begin
      if ((reg_sel == REG_CTRL) && wstrb[0]) begin
        enable_d = data_i[0];
        irq_en_d = data_i[1];
        pol_d    = data_i[4 +: CHANNELS];
      end
      if (reg_sel == REG_PRESC)  presc_d  = merge(presc_q,  data_i[CNT_WIDTH-1:0], wmask);
      if (reg_sel == REG_PERIOD) period_d = merge(period_q, data_i[CNT_WIDTH-1:0], wmask);
    end
  end

  // Prescaler and main counter. Disabled means both held at zero, so a
  // re-enable always starts a fresh period without a wrap.
  always_comb begin
    tick   = 1'b0;
    wrap   = 1'b0;
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!enable_q) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else begin
      if (pcnt_q == presc_q) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + CNT_WIDTH'(1);
      end
      if (tick) begin
        if (cnt_q == period_q) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // A wrap in the same cycle as a software clear keeps the flag set.
  assign flag_d = wrap | (flag_q & ~w1c);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      cnt_t cmp_q, cmp_d, cmp_act;

      always_comb begin
        cmp_d = cmp_q;
        if (wr_en && (reg_sel == 3'(4 + gi)))
          cmp_d = merge(cmp_q, data_i[CNT_WIDTH-1:0], wmask);
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cmp_q <= '0;
        else          cmp_q <= cmp_d;
      end

`ifdef PWM_SHADOW_EN
      cnt_t cmp_act_q, cmp_act_d;
      // Tracking the buffer while disabled makes the first period after
      // enable use the freshly written compare value.
      assign cmp_act_d = (wrap || !enable_q) ? cmp_q : cmp_act_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cmp_act_q <= '0;
        else          cmp_act_q <= cmp_act_d;
      end
      assign cmp_act = cmp_act_q;
`else
      assign cmp_act = cmp_q;
`endif

      // Using the next-state enable/polarity lets a disable force the idle
      // level on the very next cycle.
      assign pwm_d[gi]  = (enable_d & (cnt_q < cmp_act)) ^ pol_d[gi];
      assign cmp_rd[gi] = cmp_q;
    end
  endgenerate

  assign cnt_ext = 32'(cnt_q);

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[0]             = enable_q;
        rdata[1]             = irq_en_q;
        rdata[4 +: CHANNELS] = pol_q;
      end
      REG_PRESC:  rdata = 32'(presc_q);
      REG_PERIOD: rdata = 32'(period_q);
      REG_STATUS: rdata = {cnt_ext[15:0], 15'd0, flag_q};
      default: begin
        for (int i = 0; i < CHANNELS; i++)
          if (reg_sel == 3'(4 + i)) rdata = 32'(cmp_rd[i]);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      data_q   <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      pol_q    <= '0;
      presc_q  <= '0;
      period_q <= '0;
      flag_q   <= 1'b0;
      pcnt_q   <= '0;
      cnt_q    <= '0;
      pwm_q    <= '0;
    end else begin
      ready_q  <= select;
      if (access) data_q <= rdata;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      pol_q    <= pol_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      flag_q   <= flag_d;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end

  assign ready  = ready_q;
  assign data_o = data_q;
  assign pwm_o  = pwm_q;
  assign irq    = flag_q & irq_en_q;

  assign unused_bits = ^{addr[1:0], data_i, cnt_ext};

endmodule

// File: tb/tb_pwm_timer.sv
// -----------------------------------------------------------------------------
// tb_pwm_timer : self-checking bench for pwm_timer.
// Register access is table driven; timing-sensitive behaviour (handshake,
// duty cycle, prescaler/irq, disable, compare update) is hand sequenced with
// cycle positions counted from the negedge on which a bus task is called.
// A bus task called at negedge N executes its access at posedge N+1 and
// returns at negedge N+2.
// -----------------------------------------------------------------------------
module tb_pwm_timer;

  localparam int CW = 16;
  localparam int CH = 4;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_PRESC  = 5'h04;
  localparam logic [4:0] A_PERIOD = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C;
  localparam logic [4:0] A_CMP0   = 5'h10;
  localparam logic [4:0] A_CMP1   = 5'h14;
  localparam logic [4:0] A_CMP2   = 5'h18;
  localparam logic [4:0] A_CMP3   = 5'h1C;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          select  = 1'b0;
  logic [3:0]    wstrb   = 4'h0;
  logic [4:0]    addr    = 5'h00;
  logic [31:0]   data_i  = 32'h0;
  logic          ready;
  logic [31:0]   data_o;
  logic [CH-1:0] pwm_o;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int   hi [CH];
  int   first_rise, second_rise;
  logic prev;
  logic [31:0] rd;

  pwm_timer #(.CNT_WIDTH(CW), .CHANNELS(CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .select  (select),
    .wstrb   (wstrb),
    .addr    (addr),
    .data_i  (data_i),
    .ready   (ready),
    .data_o  (data_o),
    .pwm_o   (pwm_o),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic bus_xfer(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] r);
    select = 1'b1;
    addr   = a;
    wstrb  = s;
    data_i = d;
    @(negedge clk);
    for (int i = 0; i < 7 && !ready; i++) @(negedge clk);
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_ack addr 0x%02h: ready=%0b, required 1 within 8 cycles", a, ready);
    end
    r      = data_o;
    select = 1'b0;
    wstrb  = 4'h0;
    data_i = 32'h0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, 4'hF, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(a, 4'h0, 32'h0, r);
    check(name, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, A_CTRL,   4'h1, 32'h0000_00FF, 32'h0};
    vecs[1]  = '{1'b0, A_CTRL,   4'h0, 32'h0,         32'h0000_00F3};
    vecs[2]  = '{1'b1, A_CTRL,   4'hF, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, A_CTRL,   4'h0, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, A_PRESC,  4'hF, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b0, A_PRESC,  4'h0, 32'h0,         32'h0000_5678};
    vecs[6]  = '{1'b1, A_PRESC,  4'h2, 32'hAAAA_AAAA, 32'h0};
    vecs[7]  = '{1'b0, A_PRESC,  4'h0, 32'h0,         32'h0000_AA78};
    vecs[8]  = '{1'b1, A_PERIOD, 4'h1, 32'h0000_BEEF, 32'h0};
    vecs[9]  = '{1'b0, A_PERIOD, 4'h0, 32'h0,         32'h0000_00EF};
    vecs[10] = '{1'b1, A_PERIOD, 4'h4, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, A_PERIOD, 4'h0, 32'h0,         32'h0000_00EF};
    vecs[12] = '{1'b1, A_CMP0,   4'hF, 32'h0000_1234, 32'h0};
    vecs[13] = '{1'b0, A_CMP0,   4'h0, 32'h0,         32'h0000_1234};
    vecs[14] = '{1'b1, A_CMP3,   4'h3, 32'hDEAD_ABCD, 32'h0};
    vecs[15] = '{1'b0, A_CMP3,   4'h0, 32'h0,         32'h0000_ABCD};
    vecs[16] = '{1'b1, A_STATUS, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[17] = '{1'b0, A_STATUS, 4'h0, 32'h0,         32'h0};

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(ready),  32'h0);
    check("rst_data_o", data_o,      32'h0);
    check("rst_pwm",    32'(pwm_o),  32'h0);
    check("rst_irq",    32'(irq),    32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_reg%0d", i), 5'(i * 4), 32'h0);

    // ---------------- register access table ----------------
    for (int i = 0; i < NVEC; i++) begin
      bus_xfer(vecs[i].a, vecs[i].s, vecs[i].d, rd);
      if (vecs[i].wr)
        $display("wr   vec%0d addr 0x%02h strb %b data 0x%08h", i, vecs[i].a, vecs[i].s, vecs[i].d);
      else
        check($sformatf("vec%0d_rd_0x%02h", i, vecs[i].a), rd, vecs[i].exp);
    end

    // ---------------- bus handshake with select held 3 cycles ----------------
    wr(A_CTRL, 32'h0000_00F2);
    select = 1'b1; addr = A_CTRL; wstrb = 4'h0;
    check("bt_ready_c0", 32'(ready), 32'h0);
    @(negedge clk);
    check("bt_ready_c1", 32'(ready), 32'h1);
    check("bt_data_c1",  data_o,     32'h0000_00F2);
    @(negedge clk);
    check("bt_ready_c2", 32'(ready), 32'h1);
    @(negedge clk);
    check("bt_ready_c3", 32'(ready), 32'h1);
    select = 1'b0;
    @(negedge clk);
    check("bt_ready_drop", 32'(ready), 32'h0);
    wr(A_CTRL, 32'h0);

    // ---------------- duty cycle, PRESC=0 PERIOD=9 ----------------
    wr(A_PRESC, 32'd0);
    wr(A_PERIOD, 32'd9);
    wr(A_CMP0, 32'd3);
    wr(A_CMP1, 32'd0);
    wr(A_CMP2, 32'd10);
    wr(A_CMP3, 32'd5);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h1);              // called at N0, returns at N2
    for (int c = 0; c < CH; c++) hi[c] = 0;
    first_rise = -1; second_rise = -1;
    prev = pwm_o[0];
    for (int k = 3; k <= 32; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) if (pwm_o[c]) hi[c]++;
      if (pwm_o[0] && !prev) begin
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end
      prev = pwm_o[0];
    end
    check("duty_ch0_high_of_30", 32'(hi[0]), 32'd9);
    check("duty_ch1_high_of_30", 32'(hi[1]), 32'd0);
    check("duty_ch2_high_of_30", 32'(hi[2]), 32'd30);
    check("duty_ch3_high_of_30", 32'(hi[3]), 32'd15);
    check("duty_ch0_period",     32'(second_rise - first_rise), 32'd10);
    rd_chk("duty_status_a", A_STATUS, 32'h0001_0001);   // counter 1, flag set
    wr(A_STATUS, 32'h1);
    rd_chk("duty_status_b", A_STATUS, 32'h0005_0000);   // cleared, counter 5
    repeat (4) @(negedge clk);
    rd_chk("duty_status_c", A_STATUS, 32'h0001_0001);   // set again by next wrap

    // ---------------- prescaler / irq ----------------
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    wr(A_PRESC, 32'd3);
    wr(A_PERIOD, 32'd4);
    check("irq_idle", 32'(irq), 32'h0);
    wr(A_CTRL, 32'h3);              // called at Ns, first wrap at posedge s+21
    repeat (18) @(negedge clk);
    check("irq_before_wrap", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_at_20_cycles", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h1);
    check("irq_w1c_clear", 32'(irq), 32'h0);
    repeat (17) @(negedge clk);
    wr(A_STATUS, 32'h1);            // lands on the wrap edge
    check("irq_w1c_vs_wrap", 32'(irq), 32'h1);
    wr(A_CTRL, 32'h1);
    check("irq_en_off", 32'(irq), 32'h0);
    wr(A_STATUS, 32'h1);
    repeat (25) @(negedge clk);
    wr(A_CTRL, 32'h3);
    check("irq_flag_kept_while_masked", 32'(irq), 32'h1);

    // ---------------- polarity / disable ----------------
    wr(A_CTRL, 32'h0);
    wr(A_PRESC, 32'd0);
    wr(A_PERIOD, 32'd9);
    wr(A_CMP0, 32'd5);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h11);             // called at Ns
    rd_chk("pol_status_cnt", A_STATUS, 32'h0001_0000);
    check("pol_inverted_active", 32'(pwm_o[0]), 32'h0);
    wr(A_CTRL, 32'h10);
    check("dis_pwm_forced_pol", 32'(pwm_o[0]), 32'h1);
    rd_chk("dis_status_zero", A_STATUS, 32'h0);
    wr(A_CTRL, 32'h0);

    // ---------------- compare update mid-period ----------------
    wr(A_CMP0, 32'd3);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h1);              // called at Ns, wrap at posedge s+11
    wr(A_CMP0, 32'd7);              // executes at posedge s+3
    @(negedge clk);
`ifdef PWM_SHADOW_EN
    check("cmp_update_mid_period", 32'(pwm_o[0]), 32'h0);
`else
    check("cmp_update_mid_period", 32'(pwm_o[0]), 32'h1);
`endif
    repeat (13) @(negedge clk);
    check("cmp_new_duty_cnt6", 32'(pwm_o[0]), 32'h1);
    @(negedge clk);
    check("cmp_new_duty_cnt7", 32'(pwm_o[0]), 32'h0);
    rd_chk("cmp_readback", A_CMP0, 32'd7);

    // ---------------- reset mid-count ----------------
    wr(A_CMP0, 32'd5);
    wr(A_CTRL, 32'h3);
    repeat (15) @(negedge clk);
    check("pre_rst_irq", 32'(irq), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pwm",    32'(pwm_o), 32'h0);
    check("mid_rst_irq",    32'(irq),   32'h0);
    check("mid_rst_ready",  32'(ready), 32'h0);
    check("mid_rst_data_o", data_o,     32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("post_rst_reg%0d", i), 5'(i * 4), 32'h0);
    check("post_rst_pwm", 32'(pwm_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_timer.md
Name: pwm_timer

Overview:
- Memory-mapped 4-channel PWM timer slave on the picorv32 native bus.
- Sits beside systick/uart/spi/gpio in the SoC, decoded at 0x8000_0600–0x8000_061F.
- Consumes cpu bus cycles and drives its channel outputs out through the gpio alternate-function inputs.
- Raises a level interrupt on counter period wrap.

Parameters:
- CNT_WIDTH, 16, width of prescaler, counter, PERIOD and CMPn fields (max 32).
- CHANNELS, 4, number of PWM outputs (1..4); registers of absent channels read 0, writes ignored.

Ports:
- clk  input  1  system clock (pll_clk domain)
- reset_n  input  1  asynchronous active-low reset
- select  input  1  slave select from top-level address decode (already qualified by mem_valid)
- wstrb  input  4  byte write strobes; 0 = read
- addr  input  5  byte offset within block
- data_i  input  32  write data
- ready  output  1  access acknowledge
- data_o  output  32  registered read data
- pwm_o  output  CHANNELS  PWM outputs
- irq  output  1  level interrupt = flag & irq_en

Behaviour:
- Reset (async, reset_n low): all registers 0, ready=0, data_o=0, pwm_o=0, irq=0, counters 0.
- Handshake: an access executes in the cycle select=1 && ready=0.
  - ready rises the next cycle and data_o is valid in that same cycle.
  - ready stays 1 while select=1 and clears the cycle after select falls.
  - One access per select assertion; latency 1 cycle.
- Writes honour wstrb per byte. Writes to read-only fields are ignored. Unmapped offsets read 0.
- Register map:
  - 0x00 CTRL: [0] enable, [1] irq_en, [7:4] pol (per-channel output inversion).
  - 0x04 PRESC: [CNT_WIDTH-1:0].
  - 0x08 PERIOD: [CNT_WIDTH-1:0].
  - 0x0C STATUS: [0] wrap flag (write 1 to clear), [31:16] live counter value (read-only, lower CNT_WIDTH bits if narrower).
  - 0x10/0x14/0x18/0x1C CMP0..CMP3: [CNT_WIDTH-1:0].
- Prescaler:
  - pcnt counts 0..PRESC; tick=1 for one cycle when pcnt==PRESC, after which pcnt resets to 0.
  - PRESC=0 gives a tick every cycle.
- Counter:
  - On tick, cnt increments.
  - On tick with cnt==PERIOD: cnt←0, wrap event (flag←1, shadow compare load).
  - PERIOD=0: cnt stays 0 and a wrap occurs every tick.
- Output: pwm_o[i] = (cnt < cmp_act[i]) XOR pol[i], registered (1 cycle after cnt).
  - cmp_act=0 → constant inactive.
  - cmp_act>PERIOD → constant active (100%).
- Disable: enable=0 holds pcnt=cnt=0 and forces pwm_o[i]=pol[i].
  - Clearing enable mid-period stops the counter immediately.
  - Re-enabling starts from 0 with no wrap event.
- Flag:
  - A wrap and a software W1C in the same cycle: set wins.
  - flag is still set by wraps while irq_en=0; irq asserts as soon as irq_en is set while flag=1.
- PRESC/PERIOD writes take effect immediately; a write lowering PERIOD below the current cnt lets cnt run up to all-ones then wrap through 0 (no special case).

Optional Feature:
- PWM_SHADOW_EN defined:
  - CMPn writes land in a buffer; cmp_act loads from the buffer on each wrap event, and also while enable=0 (so the first period uses the written values).
  - Reads of CMPn return the buffer.
- Undefined: cmp_act is the CMPn register itself; writes take effect the next cycle, glitches allowed.

Test Plan:
- Reset: assert reset_n=0 mid-count with enable=1 → pwm_o=0, irq=0, all registers read 0 after release.
- Bus timing: read CTRL with select held 3 cycles → ready high from cycle 2 until the cycle after select drops; one write only when wstrb=4'b0001 for data 0x0000_00FF → CTRL reads 0x0000_00F3 (reserved bits 0).
- Duty: PRESC=0, PERIOD=9, CMP0=3, CMP1=0, CMP2=10, pol=0, enable → pwm_o[0] high 3 of every 10 cycles, pwm_o[1] constant 0, pwm_o[2] constant 1; STATUS.flag sets every 10 cycles.
- Prescaler/IRQ: PRESC=3, PERIOD=4, irq_en=1 → irq rises 20 cycles after enable; W1C clears it; W1C coincident with a wrap leaves flag=1.
- Polarity/disable: pol=4'b0001, CMP0=5; clear enable mid-period → pwm_o[0]=1 next cycle, STATUS[31:16]=0.
- PWM_SHADOW_EN: CMP0 3→7 written mid-period → duty change visible only after the next wrap; without the macro, visible within 1 cycle.
